// File: rtl/pps_phase_ctrl.sv
// pps_phase_ctrl: GPS/local 1PPS phase detector driving an oscillator tuning duty.
// Ports:
//   CLK_SYS, CLK_RST         system clock, asynchronous active-low reset
//   _1PPS_GPS, _1PPS_Local   asynchronous pulse inputs
//   Uart_Busy/En/Data        status byte handshake (0 deadband, 1 GPS leads, 2 local leads, 9 timeout)
//   PWM_Duty                 tuning duty, clamped to [DUTY_MIN, DUTY_MAX]
//   Phase_Err, Meas_Valid    signed last phase (positive: GPS leads) and its update strobe
//   LED_Lock                 LOCK_N consecutive in-deadband measurements
module pps_phase_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int DEADBAND    = 5,
  parameter int DUTY_W      = 32,
  parameter int DUTY_INIT   = 33800,
  parameter int DUTY_STEP   = 100,
  parameter int DUTY_MIN    = 30000,
  parameter int DUTY_MAX    = 36000,
  parameter int LOCK_N      = 8
) (
  input  logic              CLK_SYS,
  input  logic              CLK_RST,
  input  logic              _1PPS_GPS,
  input  logic              _1PPS_Local,
  input  logic              Uart_Busy,
  output logic              Uart_En,
  output logic [7:0]        Uart_Data,
  output logic [DUTY_W-1:0] PWM_Duty,
  output logic [CNT_W-1:0]  Phase_Err,
  output logic              Meas_Valid,
  output logic              LED_Lock
);
  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYC);
  localparam logic signed [CNT_W-1:0] DB = CNT_W'(DEADBAND);
  localparam logic [DUTY_W-1:0] DI = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W:0] ST = (DUTY_W + 1)'(DUTY_STEP);
  localparam logic [DUTY_W:0] MN = (DUTY_W + 1)'(DUTY_MIN);
  localparam logic [DUTY_W:0] MX = (DUTY_W + 1)'(DUTY_MAX);
  localparam logic [LW-1:0] LN = LW'(LOCK_N);

  typedef enum logic [2:0] {IDLE, CNT_GPS, CNT_LOC, DONE, TOUT} state_t;

  state_t state_q, state_d;
  logic [2:0] gsync_q, gsync_d, lsync_q, lsync_d;
  logic ge_q, ge_d, le_q, le_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [LW-1:0] lock_q, lock_d;
  logic pend_q, pend_d, en_q, en_d;
  logic [7:0] byte_q, byte_d, data_q, data_d;
  logic signed [CNT_W-1:0] se;
  logic pos, neg;
  logic [DUTY_W:0] up, dn, nxt, clamped;

  assign se = err_q;
  assign pos = se > DB;
  assign neg = se < -DB;
  // One bit wider so the step can never wrap before clamping.
  assign up = {1'b0, duty_q} + ST;
  assign dn = ({1'b0, duty_q} < ST) ? '0 : {1'b0, duty_q} - ST;
  assign nxt = pos ? up : neg ? dn : {1'b0, duty_q};
  assign clamped = (nxt > MX) ? MX : (nxt < MN) ? MN : nxt;

  always_comb begin
    gsync_d = {gsync_q[1:0], _1PPS_GPS};
    lsync_d = {lsync_q[1:0], _1PPS_Local};
    ge_d = gsync_q[1] & ~gsync_q[2];
    le_d = lsync_q[1] & ~lsync_q[2];
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    duty_d = duty_q;
    lock_d = lock_q;
    pend_d = pend_q;
    byte_d = byte_q;
    data_d = data_q;
    en_d = 1'b0;
    if (pend_q && !Uart_Busy) begin
      en_d = 1'b1;
      data_d = byte_q;
      pend_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (ge_q && le_q) begin
          state_d = DONE;
          err_d = '0;
        end else if (ge_q) begin
          state_d = CNT_GPS;
          cnt_d = 1;
        end else if (le_q) begin
          state_d = CNT_LOC;
          cnt_d = 1;
        end
      end
      CNT_GPS, CNT_LOC: begin
        if (state_q == CNT_GPS ? le_q : ge_q) begin
          state_d = DONE;
          err_d = (state_q == CNT_GPS) ? cnt_q : -cnt_q;
        end else if (cnt_q == TO) state_d = TOUT;
        else cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d = '0;
        duty_d = clamped[DUTY_W-1:0];
        lock_d = (pos || neg) ? '0 : (lock_q == LN) ? lock_q : lock_q + 1'b1;
        pend_d = 1'b1;
        byte_d = pos ? 8'd1 : neg ? 8'd2 : 8'd0;
      end
      TOUT: begin
        state_d = IDLE;
        cnt_d = '0;
        duty_d = DI;
        lock_d = '0;
        pend_d = 1'b1;
        byte_d = 8'd9;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q <= IDLE;
      gsync_q <= '0;
      lsync_q <= '0;
      ge_q <= 1'b0;
      le_q <= 1'b0;
      cnt_q <= '0;
      err_q <= '0;
      duty_q <= DI;
      lock_q <= '0;
      pend_q <= 1'b0;
      byte_q <= '0;
      data_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gsync_q <= gsync_d;
      lsync_q <= lsync_d;
      ge_q <= ge_d;
      le_q <= le_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      duty_q <= duty_d;
      lock_q <= lock_d;
      pend_q <= pend_d;
      byte_q <= byte_d;
      data_q <= data_d;
      en_q <= en_d;
    end
  end

  assign Uart_En = en_q;
  assign Uart_Data = data_q;
  assign PWM_Duty = duty_q;
  assign Phase_Err = err_q;
  assign Meas_Valid = (state_q == DONE);
  assign LED_Lock = (lock_q == LN);
endmodule

// File: tb/tb_pps_phase_ctrl.sv
// tb_pps_phase_ctrl: scoreboard bench for pps_phase_ctrl.
module tb_pps_phase_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, gps = 1'b0, loc = 1'b0, busy = 1'b0;
  logic en, mv, led, en_h, mv_h, led_h;
  logic [7:0] data, data_h;
  logic [31:0] duty, err, duty_h, err_h;

  typedef struct {int code; int duty; int lock;} ux_t;
  longint mv_q[$];
  ux_t ux_q[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pps_phase_ctrl #(.TIMEOUT_CYC(300)) dut (
    .CLK_SYS(clk), .CLK_RST(rst_n), ._1PPS_GPS(gps), ._1PPS_Local(loc), .Uart_Busy(busy),
    .Uart_En(en), .Uart_Data(data), .PWM_Duty(duty), .Phase_Err(err), .Meas_Valid(mv), .LED_Lock(led)
  );

  pps_phase_ctrl #(.TIMEOUT_CYC(300), .DUTY_INIT(35950)) u_hi (
    .CLK_SYS(clk), .CLK_RST(rst_n), ._1PPS_GPS(gps), ._1PPS_Local(loc), .Uart_Busy(busy),
    .Uart_En(en_h), .Uart_Data(data_h), .PWM_Duty(duty_h), .Phase_Err(err_h), .Meas_Valid(mv_h), .LED_Lock(led_h)
  );

  task automatic chk(input string n, input longint a, input longint e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  always @(negedge clk) begin
    if (mv) begin
      if (mv_q.size() == 0) chk("unexpected_meas_valid", 1, 0);
      else chk("phase_err", longint'($signed(err)), mv_q.pop_front());
    end
    if (en) begin
      if (ux_q.size() == 0) chk("unexpected_uart_en", 1, 0);
      else begin
        ux_t e;
        e = ux_q.pop_front();
        chk("uart_code", data, e.code);
        chk("uart_duty", duty, e.duty);
        chk("uart_lock", led, e.lock);
      end
    end
  end

  task automatic chk_reset(input string n);
    chk({n, "_duty"}, duty, 33800);
    chk({n, "_err"}, err, 0);
    chk({n, "_en"}, en, 0);
    chk({n, "_mv"}, mv, 0);
    chk({n, "_data"}, data, 0);
    chk({n, "_lock"}, led, 0);
  endtask

  // d > 0: GPS leads by d cycles; d < 0: local leads; d == 0: simultaneous.
  task automatic meas(input int d, input int ed, input int ec, input int el, input bit pu);
    mv_q.push_back(d);
    if (pu) ux_q.push_back('{code: ec, duty: ed, lock: el});
    @(negedge clk);
    if (d >= 0) gps = 1'b1;
    if (d <= 0) loc = 1'b1;
    repeat (d < 0 ? -d : d) @(negedge clk);
    gps = 1'b1;
    loc = 1'b1;
    repeat (5) @(negedge clk);
    gps = 1'b0;
    loc = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset_hold");
    chk("hi_reset_duty", duty_h, 35950);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset_rel");
    meas(100, 33900, 1, 0, 1);
    chk("hi_clamp_up", duty_h, 36000);
    for (int i = 0; i < 8; i++) meas(-3, 33900, 0, (i == 7) ? 1 : 0, 1);
    meas(50, 34000, 1, 0, 1);
    chk("hi_clamp_hold", duty_h, 36000);
    meas(0, 34000, 0, 0, 1);
    ux_q.push_back('{code: 9, duty: 33800, lock: 0});
    @(negedge clk);
    gps = 1'b1;
    repeat (20) @(negedge clk);
    gps = 1'b0;
    repeat (400) @(negedge clk);
    busy = 1'b1;
    meas(100, 33900, 1, 0, 0);
    meas(-50, 33800, 2, 0, 1);
    chk("busy_no_en", ux_q.size(), 1);
    busy = 1'b0;
    repeat (10) @(negedge clk);
    gps = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    gps = 1'b0;
    chk_reset("midrst_hold");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_reset("midrst_rel");
    meas(-7, 33700, 2, 0, 1);
    repeat (20) @(negedge clk);
    chk("mv_queue_left", mv_q.size(), 0);
    chk("uart_queue_left", ux_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
